// File: rtl/cardinal_pkg.sv
// Shared encodings for the cardinal hazard controller: opcodes, functs, NOP word, FSM states.
package cardinal_pkg;

    localparam logic [0:5] R_ALU     = 6'b101010;
    localparam logic [0:5] LOAD      = 6'b100000;
    localparam logic [0:5] STORE     = 6'b100001;
    localparam logic [0:5] BRANCH_EZ = 6'b100010;
    localparam logic [0:5] BRANCH_NZ = 6'b100011;
    localparam logic [0:5] NOP       = 6'b111100;

    localparam logic [0:5] VDIV      = 6'b001110;
    localparam logic [0:5] VMOD      = 6'b001111;
    localparam logic [0:5] VSQRT     = 6'b010010;

    localparam logic [0:31] NOP_WORD = 32'hF000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2,
        MDU_WAIT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/cardinal_src_decode.sv
// Combinational source-operand decode of the instruction held in IF/ID.
module cardinal_src_decode
    import cardinal_pkg::*;
(
    input  logic [0:31] id_instr,
    input  logic        id_valid,
    output logic [0:4]  src1,
    output logic [0:4]  src2,
    output logic        src1_used,
    output logic        src2_used,
    output logic        is_branch,
    output logic        is_mdu
);

    logic [0:5] w_opcode;
    logic [0:4] w_rd;
    logic [0:4] w_ra;
    logic [0:4] w_rb;
    logic [0:5] w_funct;
    logic       w_unused_bits;

    assign w_opcode      = id_instr[0:5];
    assign w_rd          = id_instr[6:10];
    assign w_ra          = id_instr[11:15];
    assign w_rb          = id_instr[16:20];
    assign w_funct       = id_instr[26:31];
    assign w_unused_bits = ^id_instr[21:25];

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        src1      = '0;
        src2      = '0;
        src1_used = 1'b0;
        src2_used = 1'b0;
        is_branch = 1'b0;
        is_mdu    = 1'b0;
        if (id_valid) begin
            case (w_opcode)
                R_ALU: begin
                    src1      = w_ra;
                    src2      = w_rb;
                    src1_used = 1'b1;
                    src2_used = 1'b1;
                    is_mdu    = (w_funct == VDIV) || (w_funct == VMOD) || (w_funct == VSQRT);
                end
                STORE: begin
                    src1      = w_ra;
                    src2      = w_rd;
                    src1_used = 1'b1;
                    src2_used = 1'b1;
                end
                LOAD: begin
                    src1      = w_ra;
                    src1_used = 1'b1;
                end
                BRANCH_EZ, BRANCH_NZ: begin
                    src1      = w_rd;
                    src1_used = 1'b1;
                    is_branch = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cardinal_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, taken-branch flush, multi-cycle unit wait.
// Multi-cycle unit support is compiled in only when CARDINAL_MDU_EN is defined.
module cardinal_hazard_ctrl
    import cardinal_pkg::*;
#(
    parameter int STALL_MAX = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [0:31] id_instr,
    input  logic        id_valid,
    input  logic [0:4]  ex_rd,
    input  logic        ex_reg_wr,
    input  logic [0:4]  wb_rd,
    input  logic        wb_reg_wr,
    input  logic        br_taken,
    input  logic        mdu_done,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        mdu_start,
    output logic [1:0]  hz_state
);

    localparam int CNT_W  = $clog2(STALL_MAX + 1);
    localparam int EX_LEN = (STALL_MAX < 2) ? STALL_MAX : 2;
    localparam int WB_LEN = (STALL_MAX < 1) ? STALL_MAX : 1;

    hz_state_t        r_state;
    hz_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [0:4] w_src1;
    logic [0:4] w_src2;
    logic       w_src1_used;
    logic       w_src2_used;
    logic       w_is_branch;
    logic       w_is_mdu;
    logic       w_ex_hit;
    logic       w_wb_hit;
    logic       w_raw;
    logic       w_br_req;
    logic       w_mdu_req;
    logic       w_mdu_done;

    cardinal_src_decode u_src_decode (
        .id_instr  (id_instr),
        .id_valid  (id_valid),
        .src1      (w_src1),
        .src2      (w_src2),
        .src1_used (w_src1_used),
        .src2_used (w_src2_used),
        .is_branch (w_is_branch),
        .is_mdu    (w_is_mdu)
    );

    assign w_ex_hit = ex_reg_wr && ((w_src1_used && (w_src1 == ex_rd)) ||
                                    (w_src2_used && (w_src2 == ex_rd)));
    assign w_wb_hit = wb_reg_wr && ((w_src1_used && (w_src1 == wb_rd)) ||
                                    (w_src2_used && (w_src2 == wb_rd)));
    assign w_raw    = w_ex_hit || w_wb_hit;
    assign w_br_req = w_is_branch && br_taken;

`ifdef CARDINAL_MDU_EN
    assign w_mdu_req  = w_is_mdu;
    assign w_mdu_done = mdu_done;
`else
    logic w_unused_mdu;
    assign w_mdu_req    = 1'b0;
    assign w_mdu_done   = 1'b0;
    assign w_unused_mdu = w_is_mdu ^ mdu_done;
`endif

    // NOTE: synchronous reset, so it lives inside the clocked branch and is not in the sensitivity list.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // EX match is tested first so the longer stall wins when both stages match.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            RUN: begin
                if (w_ex_hit) begin
                    w_cnt_next = CNT_W'(EX_LEN);
                    w_next     = STALL;
                end else if (w_wb_hit) begin
                    w_cnt_next = CNT_W'(WB_LEN);
                    w_next     = STALL;
                end else if (w_br_req) begin
                    w_next = FLUSH;
                end else if (w_mdu_req) begin
                    w_next = MDU_WAIT;
                end
            end
            STALL: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_next = '0;
                    w_next     = RUN;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            FLUSH:    w_next = RUN;
            MDU_WAIT: if (w_mdu_done) w_next = RUN;
            default:  w_next = RUN;
        endcase
    end

    // While Reset is high the outputs already show the RUN defaults.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mdu_start    = 1'b0;
        hz_state     = RUN;
        if (!Reset) begin
            hz_state = r_state;
            case (r_state)
                RUN: begin
                    if (!w_raw) begin
                        if (w_br_req) begin
                            if_id_flush = 1'b1;
                        end else if (w_mdu_req) begin
                            mdu_start = 1'b1;
                        end
                    end
                end
                STALL: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                MDU_WAIT: begin
                    if (!w_mdu_done) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_hazard_ctrl.sv
// Directed self-checking bench for cardinal_hazard_ctrl; MDU cases run when CARDINAL_MDU_EN is defined.
module tb_cardinal_hazard_ctrl;

    // Observed vector: {pc_en, if_id_en, if_id_flush, id_ex_bubble, mdu_start, hz_state[1:0]}
    localparam logic [6:0] O_RUN   = 7'b11_0_0_0_00;
    localparam logic [6:0] O_STALL = 7'b00_0_1_0_01;
    localparam logic [6:0] O_BRF   = 7'b11_1_0_0_00;
    localparam logic [6:0] O_FLUSH = 7'b11_0_0_0_10;
    localparam logic [6:0] O_START = 7'b11_0_0_1_00;
    localparam logic [6:0] O_WAIT  = 7'b00_0_1_0_11;
    localparam logic [6:0] O_DONE  = 7'b11_0_0_0_11;

    localparam logic [0:5] T_RALU  = 6'b101010;
    localparam logic [0:5] T_LOAD  = 6'b100000;
    localparam logic [0:5] T_STORE = 6'b100001;
    localparam logic [0:5] T_BEZ   = 6'b100010;
    localparam logic [0:5] T_BNEZ  = 6'b100011;
    localparam logic [0:5] T_VDIV  = 6'b001110;
    localparam logic [0:5] T_VMOD  = 6'b001111;
    localparam logic [0:5] T_VSQRT = 6'b010010;
    localparam logic [0:31] T_NOPW = 32'hF000_0000;

    logic        Clock;
    logic        Reset;
    logic [0:31] id_instr;
    logic        id_valid;
    logic [0:4]  ex_rd;
    logic        ex_reg_wr;
    logic [0:4]  wb_rd;
    logic        wb_reg_wr;
    logic        br_taken;
    logic        mdu_done;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        mdu_start;
    logic [1:0]  hz_state;

    int n_vec = 0;
    int n_err = 0;

    cardinal_hazard_ctrl #(.STALL_MAX(2)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .ex_rd        (ex_rd),
        .ex_reg_wr    (ex_reg_wr),
        .wb_rd        (wb_rd),
        .wb_reg_wr    (wb_reg_wr),
        .br_taken     (br_taken),
        .mdu_done     (mdu_done),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .mdu_start    (mdu_start),
        .hz_state     (hz_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [0:31] mk(input logic [0:5] op, input logic [0:4] rd,
                                       input logic [0:4] ra, input logic [0:4] rb,
                                       input logic [0:5] fn);
        return {op, rd, ra, rb, 5'b00000, fn};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got[6:0], exp[6:0]);
        end
    endtask

    task automatic drive(input logic [0:31] ins, input logic v,
                         input logic [0:4] exr, input logic exw,
                         input logic [0:4] wbr, input logic wbw, input logic br);
        id_instr  = ins;
        id_valid  = v;
        ex_rd     = exr;
        ex_reg_wr = exw;
        wb_rd     = wbr;
        wb_reg_wr = wbw;
        br_taken  = br;
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge Clock);
        check(tag, {25'b0, pc_en, if_id_en, if_id_flush, id_ex_bubble, mdu_start, hz_state},
              {25'b0, exp});
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        drive(T_NOPW, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset    = 1'b1;
        mdu_done = 1'b0;
        drive(T_NOPW, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("reset_a", O_RUN);
        cyc("reset_b", O_RUN);
        Reset = 1'b0;
        idle();
        cyc("idle_nop", O_RUN);

        // EX-distance RAW on rA: two stall cycles, then RUN
        drive(mk(T_RALU, 5'd1, 5'd3, 5'd4, 6'd0), 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        cyc("raw_ex_detect", O_RUN);
        ex_reg_wr = 1'b0;
        cyc("raw_ex_stall1", O_STALL);
        cyc("raw_ex_stall2", O_STALL);
        cyc("raw_ex_back", O_RUN);

        // WB-distance RAW on STORE rD: one stall cycle
        drive(mk(T_STORE, 5'd5, 5'd9, 5'd0, 6'd0), 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        cyc("raw_wb_detect", O_RUN);
        wb_reg_wr = 1'b0;
        cyc("raw_wb_stall1", O_STALL);
        cyc("raw_wb_back", O_RUN);

        // Both stages match rB: EX wins, two stalls not three
        drive(mk(T_RALU, 5'd2, 5'd1, 5'd7, 6'd0), 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
        cyc("raw_both_detect", O_RUN);
        ex_reg_wr = 1'b0;
        wb_reg_wr = 1'b0;
        cyc("raw_both_stall1", O_STALL);
        cyc("raw_both_stall2", O_STALL);
        cyc("raw_both_back", O_RUN);

        // r0 is compared like any other register
        drive(mk(T_LOAD, 5'd4, 5'd0, 5'd0, 6'd0), 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        cyc("raw_r0_detect", O_RUN);
        ex_reg_wr = 1'b0;
        cyc("raw_r0_stall1", O_STALL);
        cyc("raw_r0_stall2", O_STALL);
        cyc("raw_r0_back", O_RUN);

        // Non-hazards: LOAD rD / rB are not sources, write disabled, invalid ID
        drive(mk(T_LOAD, 5'd7, 5'd1, 5'd7, 6'd0), 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
        cyc("nohz_load_rd", O_RUN);
        cyc("nohz_load_rd_stay", O_RUN);
        drive(mk(T_RALU, 5'd1, 5'd8, 5'd8, 6'd0), 1'b1, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc("nohz_no_wr", O_RUN);
        drive(mk(T_RALU, 5'd1, 5'd8, 5'd8, 6'd0), 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0);
        cyc("nohz_invalid", O_RUN);
        cyc("nohz_invalid_stay", O_RUN);

        // Taken branch: flush, FLUSH state for one cycle, back to RUN
        drive(mk(T_BEZ, 5'd2, 5'd0, 5'd0, 6'd0), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("br_flush", O_BRF);
        idle();
        cyc("br_flush_state", O_FLUSH);
        cyc("br_back", O_RUN);

        drive(mk(T_BNEZ, 5'd2, 5'd0, 5'd0, 6'd0), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("br_not_taken", O_RUN);

        // Branch held by a RAW stall is re-evaluated afterwards
        drive(mk(T_BNEZ, 5'd6, 5'd0, 5'd0, 6'd0), 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        cyc("br_raw_detect", O_RUN);
        wb_reg_wr = 1'b0;
        cyc("br_raw_stall", O_STALL);
        cyc("br_raw_reeval", O_BRF);
        idle();
        cyc("br_raw_flush_state", O_FLUSH);
        cyc("br_raw_back", O_RUN);

        // Reset in the middle of a RAW stall abandons it
        drive(mk(T_RALU, 5'd1, 5'd3, 5'd4, 6'd0), 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        cyc("rst_stall_detect", O_RUN);
        ex_reg_wr = 1'b0;
        cyc("rst_stall_stall1", O_STALL);
        Reset    = 1'b1;
        id_valid = 1'b0;
        cyc("rst_stall_during", O_RUN);
        Reset = 1'b0;
        idle();
        cyc("rst_stall_after", O_RUN);
        cyc("rst_stall_stay", O_RUN);

`ifdef CARDINAL_MDU_EN
        // VSQRT: one start pulse, wait, done six cycles later releases the same cycle
        drive(mk(T_RALU, 5'd1, 5'd2, 5'd3, T_VSQRT), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("mdu_start", O_START);
        for (int i = 1; i <= 5; i++) cyc($sformatf("mdu_wait%0d", i), O_WAIT);
        mdu_done = 1'b1;
        cyc("mdu_done_release", O_DONE);
        mdu_done = 1'b0;
        idle();
        cyc("mdu_back", O_RUN);

        // Stray done in RUN is ignored
        mdu_done = 1'b1;
        cyc("mdu_stray_done", O_RUN);
        mdu_done = 1'b0;
        cyc("mdu_stray_stay", O_RUN);

        // RAW beats MDU start; start follows the stall
        drive(mk(T_RALU, 5'd1, 5'd4, 5'd3, T_VMOD), 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        cyc("mdu_raw_detect", O_RUN);
        wb_reg_wr = 1'b0;
        cyc("mdu_raw_stall", O_STALL);
        cyc("mdu_raw_start", O_START);
        mdu_done = 1'b1;
        cyc("mdu_raw_done", O_DONE);
        mdu_done = 1'b0;
        idle();
        cyc("mdu_raw_back", O_RUN);

        // Reset on the third MDU_WAIT cycle
        drive(mk(T_RALU, 5'd1, 5'd2, 5'd3, T_VDIV), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("mdu_rst_start", O_START);
        cyc("mdu_rst_wait1", O_WAIT);
        cyc("mdu_rst_wait2", O_WAIT);
        Reset    = 1'b1;
        id_valid = 1'b0;
        cyc("mdu_rst_during", O_RUN);
        Reset = 1'b0;
        idle();
        cyc("mdu_rst_after", O_RUN);
        cyc("mdu_rst_stay", O_RUN);
`else
        // Without the unit VSQRT is a plain R_ALU and done is ignored
        drive(mk(T_RALU, 5'd1, 5'd2, 5'd3, T_VSQRT), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("nomdu_vsqrt", O_RUN);
        mdu_done = 1'b1;
        cyc("nomdu_vsqrt_done", O_RUN);
        mdu_done = 1'b0;
        drive(mk(T_RALU, 5'd1, 5'd2, 5'd3, T_VDIV), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("nomdu_vdiv", O_RUN);
        cyc("nomdu_vdiv_stay", O_RUN);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cardinal_hazard_ctrl.md
CARDINAL_HAZARD_CTRL -- requirements
Module: cardinal_hazard_ctrl

Interface
REQ-001 SHALL have ports, in order:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- id_instr  in  32 [0:31]  instruction in the IF/ID register
- id_valid  in  1  IF/ID holds a real instruction
- ex_rd  in  5 [0:4]  destination register in EX/MEM
- ex_reg_wr  in  1  EX/MEM writes the register file
- wb_rd  in  5 [0:4]  destination register in WB
- wb_reg_wr  in  1  WB writes the register file
- br_taken  in  1  ID branch comparator result
- mdu_done  in  1  multi-cycle unit result ready (1-cycle pulse)
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  load IF/ID with NOP 0xF0000000
- id_ex_bubble  out  1  load ID/EX control with zeros
- mdu_start  out  1  start pulse to the multi-cycle unit
- hz_state  out  2  current FSM state
REQ-002 SHALL have parameter STALL_MAX, default 2, the maximum RAW stall length.

Function
REQ-003 SHALL decode fields: opcode [0:5], rD [6:10], rA [11:15], rB [16:20], funct [26:31].
REQ-004 SHALL define sources as follows:
- R_ALU (101010) uses rA and rB.
- STORE (100001) uses rA and rD.
- LOAD (100000) uses rA.
- BEZ (100010) and BNEZ (100011) use rD.
- NOP (111100) and unknown opcodes use none.
REQ-005 SHALL flag a RAW hazard when id_valid=1 and any source equals ex_rd with ex_reg_wr=1 (distance 2) or equals wb_rd with wb_reg_wr=1 (distance 1). All 32 registers, including r0, SHALL be compared.
REQ-006 SHALL use FSM states RUN=0, STALL=1, FLUSH=2, MDU_WAIT=3.
REQ-007 In RUN, with a RAW hazard: load stall counter with 2 (EX match) or 1 (WB only); go to STALL.
REQ-008 In STALL: pc_en=0, if_id_en=0, id_ex_bubble=1; decrement counter each cycle; return to RUN the cycle after it reaches 0.
REQ-009 An EX match SHALL take priority over a WB match, so the longer stall wins.
REQ-010 In RUN, with no hazard and a branch in ID with br_taken=1: if_id_flush=1 that cycle; go to FLUSH for one cycle with pc_en=1.
REQ-011 In FLUSH: return to RUN next cycle.
REQ-012 In RUN, with no hazard and R_ALU funct VDIV (001110), VMOD (001111) or VSQRT (010010):
- assert mdu_start for exactly one cycle;
- go to MDU_WAIT.
REQ-013 In MDU_WAIT: pc_en=0, if_id_en=0, id_ex_bubble=1 until mdu_done=1.
REQ-014 On mdu_done=1 in MDU_WAIT: release all stalls the same cycle; go to RUN.
REQ-015 mdu_done outside MDU_WAIT SHALL be ignored.
REQ-016 Priority in RUN SHALL be RAW hazard > branch > MDU start.
REQ-017 A branch or MDU instruction held by a RAW stall SHALL be re-evaluated in RUN after the stall.
REQ-018 In RUN with no event: pc_en=1, if_id_en=1, all other outputs 0.
REQ-019 All outputs SHALL be combinational from state, counter and inputs, with no added latency.

Reset
REQ-020 Reset SHALL force state=RUN and counter=0.
REQ-021 Outputs during and after reset SHALL be: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0, mdu_start=0, hz_state=0.
REQ-022 Reset during STALL or MDU_WAIT SHALL abandon the operation, with no mdu_start on exit.

Configuration
REQ-023 Macro CARDINAL_MDU_EN SHALL select multi-cycle unit support.
- Defined: REQ-012..015 apply.
- Undefined: VDIV, VMOD and VSQRT are treated as single-cycle R_ALU; mdu_start=0; MDU_WAIT is unreachable; mdu_done is ignored.

Structure
REQ-024 Shared package cardinal_pkg SHALL hold:
- opcode constants R_ALU, LOAD, STORE, BRANCH_EZ, BRANCH_NZ, NOP;
- funct constants VDIV, VMOD, VSQRT;
- the NOP word 0xF0000000;
- the 2-bit state encoding.
REQ-025 Sub-module cardinal_src_decode SHALL be combinational: id_instr/id_valid -> src1, src2, src1_used, src2_used, is_branch, is_mdu.

Verification
REQ-026 R_ALU r3 in EX (ex_rd=3, ex_reg_wr=1), ID R_ALU with rA=3 -> exactly 2 cycles of pc_en=0, id_ex_bubble=1, then RUN.
REQ-027 wb_rd=5, wb_reg_wr=1, ID STORE with rD=5 -> exactly 1 stall cycle.
REQ-028 ex_rd=7 and wb_rd=7, both writing, ID R_ALU rB=7 -> 2 stall cycles, not 3.
REQ-029 ID BEZ, no hazard, br_taken=1 -> if_id_flush=1 for 1 cycle, hz_state=2 next cycle, then 0.
REQ-030 ID R_ALU funct VSQRT with CARDINAL_MDU_EN defined -> mdu_start 1 cycle; stall until mdu_done arrives 6 cycles later; pc_en=1 the same cycle as mdu_done.
REQ-031 Reset asserted on the 3rd cycle of MDU_WAIT -> next cycle hz_state=0, pc_en=1, mdu_start=0.
